// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU between two requesters (IDLE/EXEC/HOLD FSM, 2-way round-robin)
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_a/req_b/req_op carry two packed
// requesters; rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_zero/rsp_geq form the response channel;
// alu_a/alu_b/alu_op drive the shared ALU and alu_result/alu_zero/alu_geq return its outputs;
// busy is high outside IDLE.
// Build option: ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie and drops the last-grant register.
module alu_share_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_a,
  input  logic [127:0] req_b,
  input  logic [7:0]   req_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [63:0]  rsp_result,
  output logic         rsp_zero,
  output logic         rsp_geq,
  output logic [63:0]  alu_a,
  output logic [63:0]  alu_b,
  output logic [3:0]   alu_op,
  input  logic [63:0]  alu_result,
  input  logic         alu_zero,
  input  logic         alu_geq,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state;
  logic g;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign g = ~req_valid[0];
`else
  logic last;
  // on a tie the requester not granted last wins; otherwise the lone requester
  assign g = &req_valid ? ~last : req_valid[1];
`endif
  assign req_ready = (state == IDLE && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_geq    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          state  <= EXEC;
          alu_a  <= g ? req_a[127:64] : req_a[63:0];
          alu_b  <= g ? req_b[127:64] : req_b[63:0];
          alu_op <= g ? req_op[7:4] : req_op[3:0];
          rsp_id <= g;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last   <= g;
`endif
        end
        EXEC: begin
          state      <= HOLD;
          rsp_valid  <= 1'b1;
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_geq    <= alu_geq;
        end
        HOLD: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table, corner sequences and random traffic against a transaction-level model
module tb_alu_share_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [7:0]   req_op = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [63:0]  rsp_result;
  logic         rsp_zero;
  logic         rsp_geq;
  logic [63:0]  alu_a;
  logic [63:0]  alu_b;
  logic [3:0]   alu_op;
  logic [63:0]  alu_result;
  logic         alu_zero;
  logic         alu_geq;
  logic         busy;
  always #5 clk = ~clk;
  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_geq(rsp_geq), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_geq(alu_geq), .busy(busy)
  );
  function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1100: return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_a, alu_b, alu_op);
  assign alu_zero = alu_result == 64'd0;
  assign alu_geq = alu_a >= alu_b;
  int errs = 0;
  int checks = 0;
  bit m_busy = 1'b0;
  int m_age = 0;
  bit m_last = 1'b1;
  logic m_id;
  logic [63:0] m_a, m_b, m_res;
  logic [3:0] m_op;
  logic [1:0] p_er;
  logic p_g;
  logic [1:0] seen_ready;
  typedef struct {
    logic [1:0]   v;
    logic [127:0] a;
    logic [127:0] b;
    logic [7:0]   op;
    logic         id;
    logic [63:0]  res;
    logic         z;
    logic         ge;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive_check(input logic [1:0] v, input logic [127:0] a, input logic [127:0] b,
                             input logic [7:0] op, input logic rr);
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; req_op = op; rsp_ready = rr;
    #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    p_g = (v == 2'b11) ? 1'b0 : v[1];
`else
    p_g = (v == 2'b11) ? ~m_last : v[1];
`endif
    p_er = (!m_busy && v != 2'b00) ? (p_g ? 2'b10 : 2'b01) : 2'b00;
    seen_ready = req_ready;
    chk("req_ready", req_ready, p_er);
    chk("busy", busy, m_busy);
    chk("rsp_valid", rsp_valid, m_busy && m_age >= 2);
    if (m_busy) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
    end
    if (m_busy && m_age >= 2) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", rsp_zero, m_res == 64'd0);
      chk("rsp_geq", rsp_geq, m_a >= m_b);
    end
  endtask
  task automatic update();
    if (p_er != 2'b00) begin
      m_busy = 1'b1;
      m_age = 1;
      m_id = p_g;
      m_last = p_g;
      m_a = p_g ? req_a[127:64] : req_a[63:0];
      m_b = p_g ? req_b[127:64] : req_b[63:0];
      m_op = p_g ? req_op[7:4] : req_op[3:0];
      m_res = alu_fn(m_a, m_b, m_op);
    end else if (m_busy) begin
      if (m_age >= 2 && rsp_ready) m_busy = 1'b0;
      else m_age++;
    end
  endtask
  task automatic step(input logic [1:0] v, input logic [127:0] a, input logic [127:0] b,
                      input logic [7:0] op, input logic rr);
    drive_check(v, a, b, op, rr);
    update();
  endtask
  task automatic do_reset();
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_geq", rsp_geq, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 1'b0;
    m_last = 1'b1;
  endtask
  task automatic run_vec(input int i);
    step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1);
    step(2'b00, '0, '0, '0, 1'b1);
    drive_check(2'b00, '0, '0, '0, 1'b1);
    chk("tbl_valid", rsp_valid, 1);
    chk("tbl_id", rsp_id, tbl[i].id);
    chk("tbl_result", rsp_result, tbl[i].res);
    chk("tbl_zero", rsp_zero, tbl[i].z);
    chk("tbl_geq", rsp_geq, tbl[i].ge);
    update();
  endtask
  initial begin
    logic [3:0] ops[6];
    logic [1:0] grants[$];
    logic [127:0] ra, rb;
    logic [7:0] rop;
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'hC, 4'h9};
    tbl[0] = '{2'b01, {64'd0, 64'd5}, {64'd0, 64'd7}, 8'h02, 1'b0, 64'd12, 1'b0, 1'b0};
    tbl[1] = '{2'b10, {64'd9, 64'd0}, {64'd9, 64'd0}, 8'h60, 1'b1, 64'd0, 1'b1, 1'b1};
    tbl[2] = '{2'b01, {64'd0, 64'hFF00}, {64'd0, 64'h0FF0}, 8'h00, 1'b0, 64'h0F00, 1'b0, 1'b1};
    tbl[3] = '{2'b10, 128'd0, 128'd0, 8'hC0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    tbl[4] = '{2'b01, {64'd0, 64'd3}, {64'd0, 64'd1}, 8'h0F, 1'b0, 64'd0, 1'b1, 1'b1};
`ifdef ALU_ARB_FIXED_PRIO_EN
    tbl[5] = '{2'b11, {64'hF0, 64'd1}, {64'h0F, 64'd1}, 8'h12, 1'b0, 64'd2, 1'b0, 1'b1};
`else
    tbl[5] = '{2'b11, {64'hF0, 64'd1}, {64'h0F, 64'd1}, 8'h12, 1'b1, 64'hFF, 1'b0, 1'b1};
`endif
    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) run_vec(i);
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(2'b11, {64'd4, 64'd3}, {64'd2, 64'd1}, 8'h22, 1'b1);
      if (seen_ready != 2'b00) grants.push_back(seen_ready);
    end
    chk("grant_count", grants.size(), 3);
    while (grants.size() < 3) grants.push_back(2'b00);
    chk("grant0", grants[0], 2'b01);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("grant1", grants[1], 2'b01);
`else
    chk("grant1", grants[1], 2'b10);
`endif
    chk("grant2", grants[2], 2'b01);
    step(2'b01, {64'd0, 64'd20}, {64'd0, 64'd30}, 8'h06, 1'b0);
    step(2'b11, '1, '1, 8'hFF, 1'b0);
    repeat (4) step(2'b11, '1, '1, 8'hFF, 1'b0);
    step(2'b00, '0, '0, '0, 1'b1);
    step(2'b00, '0, '0, '0, 1'b1);
    chk("hold_release_busy", busy, 0);
    step(2'b01, {64'd0, 64'hF0}, {64'd0, 64'h0F}, 8'h01, 1'b1);
    do_reset();
    repeat (3) step(2'b00, '0, '0, '0, 1'b1);
    run_vec(0);
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = {60'd0, 4'($urandom_range(0, 3)), 60'd0, 4'($urandom_range(0, 3))};
        rb = {60'd0, 4'($urandom_range(0, 3)), 60'd0, 4'($urandom_range(0, 3))};
      end else begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
      end
      rop = {ops[$urandom_range(0, 5)], ops[$urandom_range(0, 5)]};
      step(2'($urandom_range(0, 3)), ra, rb, rop, $urandom_range(0, 3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 64 bits and the opcode at 4 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  2  bit i set = requester i offers an operation.
REQ-005 req_ready  out  2  bit i set = requester i's operation is accepted this cycle.
REQ-006 req_a  in  128  operand A; requester i in bits [64i+63:64i].
REQ-007 req_b  in  128  operand B; same packing as req_a.
REQ-008 req_op  in  8  ALU opcode; requester i in bits [4i+3:4i].
REQ-009 rsp_valid  out  1  response registers hold a completed result.
REQ-010 rsp_ready  in  1  consumer accepts the response.
REQ-011 rsp_id  out  1  index of the requester that owns the response.
REQ-012 rsp_result  out  64  captured ALU result.
REQ-013 rsp_zero  out  1  captured ALU zero flag.
REQ-014 rsp_geq  out  1  captured ALU unsigned a>=b flag.
REQ-015 alu_a, alu_b  out  64 each  registered operands to the shared ALU instance.
REQ-016 alu_op  out  4  registered opcode to the shared ALU (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR).
REQ-017 alu_result  in  64, alu_zero  in  1, alu_geq  in  1  combinational ALU outputs.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, EXEC and HOLD.
REQ-020 In IDLE, with any req_valid bit set, the block SHALL assert exactly one req_ready bit (granted index g) combinationally, latch req_a/req_b/req_op of g into alu_a/alu_b/alu_op and g into rsp_id, and go to EXEC.
REQ-021 req_ready SHALL be 0 in EXEC and HOLD and in IDLE when no request is present.
REQ-022 In EXEC, the block SHALL capture alu_result/alu_zero/alu_geq into rsp_result/rsp_zero/rsp_geq, set rsp_valid, and go to HOLD.
REQ-023 In HOLD, rsp_valid and all rsp_* outputs SHALL stay constant until rsp_ready is sampled high; then rsp_valid clears and the state returns to IDLE.
REQ-024 Latency SHALL be: accept in cycle N -> rsp_valid high from cycle N+2; minimum issue interval 3 cycles.
REQ-025 alu_a/alu_b/alu_op SHALL remain stable from acceptance until return to IDLE.
REQ-026 Arbitration SHALL be round-robin: a single requester is granted immediately; when both are valid, the one not granted last wins; the last-grant register updates on every grant.
REQ-027 Opcodes SHALL be passed through unchecked; undefined opcodes produce whatever the ALU returns (0, zero=1).
REQ-028 A requester whose req_valid drops before grant SHALL simply lose its slot; no state is retained for it.

Reset
REQ-029 On rst_n low, the block SHALL immediately force state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_geq 0, alu_a/alu_b 0, alu_op 0000, busy 0, last-grant 1 (so requester 0 wins the first tie).
REQ-030 Reset during EXEC or HOLD SHALL discard the in-flight operation with no response produced.

Configuration
REQ-031 With ALU_ARB_FIXED_PRIO_EN defined, ties SHALL always grant requester 0 and the last-grant register SHALL be absent; without it, REQ-026 round-robin applies.

Verification
REQ-032 req0 ADD a=5 b=7 alone, rsp_ready=1 -> req_ready=01 at cycle N, rsp_valid at N+2, rsp_id=0, rsp_result=12, zero=0, geq=0.
REQ-033 req1 SUB a=9 b=9 -> rsp_id=1, rsp_result=0, zero=1, geq=1.
REQ-034 Both valid from reset, held through three grants -> grant order 0,1,0 (round-robin); with ALU_ARB_FIXED_PRIO_EN -> 0,0,0.
REQ-035 rsp_ready low 4 cycles in HOLD -> rsp_* stable, req_ready=00, busy=1; on rsp_ready=1 return to IDLE next cycle.
REQ-036 rst_n pulsed low in EXEC of OR a=0xF0 b=0x0F -> no rsp_valid, all outputs at reset values, next request serviced normally.
